// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller.
// Holds the controller state enum and the time-field widths used by the
// time-of-day counters, the alarm hour/minute counters and alarm_ctrl.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [2:0] {
    IDLE,
    SET_HOUR,
    SET_MIN,
    ARMED,
    RINGING,
    SNOOZE
  } alarm_state_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// Saturating tick counter used for the ring and snooze intervals.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   clear          : synchronous return to zero (dominates tick)
//   tick           : count enable, one pulse per second while timing
//   done           : high on the tick that completes TERMINAL ticks
module alarm_sec_timer
  import alarm_pkg::*;
#(
  parameter int TERMINAL = 60
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
  localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

  logic [W-1:0] count;

  assign done = tick && (count == LAST);

  // Count ticks from zero and hold at the last value instead of wrapping;
  // the owner leaves the timed state on done and clears us on re-entry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: walks the alarm hour/minute setting sequence from the
// mode/increment buttons, detects the alarm time, and runs the buzzer with
// timed ringing, limited snoozes and disarm.
// Ports:
//   clock, reset_n            : system clock, asynchronous active-low reset
//   tick_1hz                  : one-cycle pulse per second
//   btn_mode/btn_inc/btn_stop : debounced one-cycle button pulses
//   time_hour/min/sec         : running time of day
//   alarm_hour/min            : stored alarm time from the alarm counters
//   setting_*/enable_*        : control of the alarm hour/minute counters
//   buzzer                    : sound enable while ringing
//   armed                     : alarm active (ARMED, RINGING or SNOOZE)
//   snooze_active             : snooze interval running
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              tick_1hz,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_stop,
  input  logic [HOUR_W-1:0] time_hour,
  input  logic [MIN_W-1:0]  time_min,
  input  logic [SEC_W-1:0]  time_sec,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  output logic              setting_hour,
  output logic              enable_hour,
  output logic              setting_min,
  output logic              enable_min,
  output logic              buzzer,
  output logic              armed,
  output logic              snooze_active
);

  localparam int SNZ_SECS = SNOOZE_MINS * 60;
  localparam int SCNT_W   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam logic [SCNT_W-1:0] SNOOZE_LIMIT = SCNT_W'(MAX_SNOOZE);

  alarm_state_t      state, next_state;
  logic              match, match_q, trigger;
  logic [SCNT_W-1:0] snooze_cnt;
  logic              snooze_clear, snooze_inc;
  logic              ring_clear, snz_clear, ring_done, snz_done;
  logic              ring_tick, snz_tick;

  assign match   = (time_hour == alarm_hour) && (time_min == alarm_min) &&
                   (time_sec == '0);
  assign trigger = match && !match_q;

  assign ring_tick = tick_1hz && (state == RINGING);
  assign snz_tick  = tick_1hz && (state == SNOOZE);

  alarm_sec_timer #(.TERMINAL(RING_SECS)) u_ring_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (ring_clear),
    .tick    (ring_tick),
    .done    (ring_done)
  );

  alarm_sec_timer #(.TERMINAL(SNZ_SECS)) u_snooze_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (snz_clear),
    .tick    (snz_tick),
    .done    (snz_done)
  );

  // State register plus the previous-cycle match flag. match_q resets high
  // so a matching time present at reset release is not seen as an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      match_q <= 1'b1;
    end else begin
      state   <= next_state;
      match_q <= match;
    end
  end

  // Snoozes used in the current alarm event; saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snooze_cnt <= '0;
    end else if (snooze_clear) begin
      snooze_cnt <= '0;
    end else if (snooze_inc && (snooze_cnt != SNOOZE_LIMIT)) begin
      snooze_cnt <= snooze_cnt + 1'b1;
    end
  end

  // Next-state logic. Buttons are tested in priority order mode > stop >
  // inc > timer events; a button that has no effect in the current state
  // (including inc once the snooze limit is reached) does not mask a
  // lower-priority event.
  always_comb begin
    next_state   = state;
    ring_clear   = 1'b0;
    snz_clear    = 1'b0;
    snooze_inc   = 1'b0;
    snooze_clear = 1'b0;
    case (state)
      IDLE: begin
        if (btn_mode) next_state = SET_HOUR;
      end
      SET_HOUR: begin
        if (btn_mode) next_state = SET_MIN;
      end
      SET_MIN: begin
        if (btn_mode) next_state = ARMED;
      end
      ARMED: begin
        if (btn_mode) begin
          next_state = IDLE;
        end else if (trigger) begin
          next_state = RINGING;
          ring_clear = 1'b1;
        end
      end
      RINGING: begin
        if (btn_mode) begin
          next_state = IDLE;
        end else if (btn_stop) begin
          next_state = ARMED;
        end else if (btn_inc && (snooze_cnt < SNOOZE_LIMIT)) begin
          next_state = SNOOZE;
          snz_clear  = 1'b1;
        end else if (ring_done) begin
          next_state = ARMED;
        end
      end
      SNOOZE: begin
        if (btn_mode) begin
          next_state = IDLE;
        end else if (btn_stop) begin
          next_state = ARMED;
        end else if (snz_done) begin
          next_state = RINGING;
          ring_clear = 1'b1;
          snooze_inc = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    // Any arrival in ARMED or IDLE starts a fresh alarm event.
    if ((next_state != state) && ((next_state == ARMED) || (next_state == IDLE)))
      snooze_clear = 1'b1;
  end

  // Moore decodes of the state register.
  assign setting_hour  = (state == SET_HOUR);
  assign setting_min   = (state == SET_MIN);
  assign buzzer        = (state == RINGING);
  assign snooze_active = (state == SNOOZE);
  assign armed         = (state == ARMED) || (state == RINGING) || (state == SNOOZE);

  // Counter increments follow btn_inc in the same cycle, suppressed when
  // btn_mode wins the cycle and moves on to the next field.
  assign enable_hour = setting_hour && btn_inc && !btn_mode;
  assign enable_min  = setting_min && btn_inc && !btn_mode;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed walk-through of setting,
// trigger, late arm, snooze, priority and async reset, then randomized
// buttons/ticks/time jumps checked every cycle against a behavioural model.
module tb_alarm_ctrl;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_MINS = 5;
  localparam int MAX_SNOOZE  = 3;

  localparam int M_OFF  = 0;
  localparam int M_SETH = 1;
  localparam int M_SETM = 2;
  localparam int M_ARM  = 3;
  localparam int M_RING = 4;
  localparam int M_SNZ  = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_stop = 1'b0;
  logic [4:0] time_hour = '0;
  logic [5:0] time_min = '0, time_sec = '0;
  logic [4:0] alarm_hour = '0;
  logic [5:0] alarm_min = '0;
  logic       setting_hour, enable_hour, setting_min, enable_min;
  logic       buzzer, armed, snooze_active;

  int n_compared = 0;
  int n_mismatched = 0;

  // Bench-side time of day and alarm setting
  int t_h = 12, t_m = 0, t_s = 10;
  int a_h = 7, a_m = 30;

  // Behavioural model: current mode, seconds left in the timed interval,
  // snoozes used this event, match seen on the previous cycle
  int m_mode = M_OFF;
  int ring_left = 0;
  int snz_left = 0;
  int snoozes_used = 0;
  bit prev_match = 1'b1;

  alarm_ctrl #(
    .RING_SECS   (RING_SECS),
    .SNOOZE_MINS (SNOOZE_MINS),
    .MAX_SNOOZE  (MAX_SNOOZE)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .tick_1hz      (tick_1hz),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .btn_stop      (btn_stop),
    .time_hour     (time_hour),
    .time_min      (time_min),
    .time_sec      (time_sec),
    .alarm_hour    (alarm_hour),
    .alarm_min     (alarm_min),
    .setting_hour  (setting_hour),
    .enable_hour   (enable_hour),
    .setting_min   (setting_min),
    .enable_min    (enable_min),
    .buzzer        (buzzer),
    .armed         (armed),
    .snooze_active (snooze_active)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_OFF;
    ring_left = 0;
    snz_left = 0;
    snoozes_used = 0;
    prev_match = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit match, rise;
    int nxt;
    match = (t_h == a_h) && (t_m == a_m) && (t_s == 0);
    rise = match && !prev_match;
    prev_match = match;
    nxt = m_mode;
    case (m_mode)
      M_OFF:  if (btn_mode) nxt = M_SETH;
      M_SETH: if (btn_mode) nxt = M_SETM;
      M_SETM: if (btn_mode) nxt = M_ARM;
      M_ARM: begin
        if (btn_mode) nxt = M_OFF;
        else if (rise) begin nxt = M_RING; ring_left = RING_SECS; end
      end
      M_RING: begin
        if (btn_mode) nxt = M_OFF;
        else if (btn_stop) nxt = M_ARM;
        else if (btn_inc && snoozes_used < MAX_SNOOZE) begin
          nxt = M_SNZ;
          snz_left = SNOOZE_MINS * 60;
        end else if (tick_1hz) begin
          ring_left--;
          if (ring_left == 0) nxt = M_ARM;
        end
      end
      M_SNZ: begin
        if (btn_mode) nxt = M_OFF;
        else if (btn_stop) nxt = M_ARM;
        else if (tick_1hz) begin
          snz_left--;
          if (snz_left == 0) begin
            nxt = M_RING;
            ring_left = RING_SECS;
            snoozes_used++;
          end
        end
      end
      default: nxt = M_OFF;
    endcase
    m_mode = nxt;
    if (m_mode == M_OFF || m_mode == M_ARM) snoozes_used = 0;
  endtask

  task automatic advance_time();
    t_s++;
    if (t_s == 60) begin t_s = 0; t_m++; end
    if (t_m == 60) begin t_m = 0; t_h++; end
    if (t_h == 24) t_h = 0;
  endtask

  task automatic check_model();
    bit mode_wins;
    mode_wins = btn_mode;
    checkOutput("buzzer", int'(buzzer), int'(m_mode == M_RING));
    checkOutput("armed", int'(armed), int'(m_mode >= M_ARM));
    checkOutput("snooze_active", int'(snooze_active), int'(m_mode == M_SNZ));
    checkOutput("setting_hour", int'(setting_hour), int'(m_mode == M_SETH));
    checkOutput("setting_min", int'(setting_min), int'(m_mode == M_SETM));
    checkOutput("enable_hour", int'(enable_hour), int'(m_mode == M_SETH && btn_inc && !mode_wins));
    checkOutput("enable_min", int'(enable_min), int'(m_mode == M_SETM && btn_inc && !mode_wins));
  endtask

  // One clock cycle: drive after the rising edge, check on the falling
  // edge, then step the model and the bench time of day.
  task automatic applyStimulus(input bit mode, input bit inc, input bit stop, input bit tick);
    @(posedge clock);
    #1;
    btn_mode = mode;
    btn_inc = inc;
    btn_stop = stop;
    tick_1hz = tick;
    time_hour = 5'(t_h);
    time_min = 6'(t_m);
    time_sec = 6'(t_s);
    alarm_hour = 5'(a_h);
    alarm_min = 6'(a_m);
    @(negedge clock);
    check_model();
    model_step();
    if (tick) advance_time();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic arm_alarm();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
  endtask

  task automatic ring_from_arm();
    t_h = 7; t_m = 29; t_s = 59;
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  initial begin
    int pulses;
    int ticks;
    $display("[TB] start");

    // Reset state
    #13;
    @(negedge clock);
    checkOutput("rst_buzzer", int'(buzzer), 0);
    checkOutput("rst_armed", int'(armed), 0);
    checkOutput("rst_snooze", int'(snooze_active), 0);
    checkOutput("rst_set_hour", int'(setting_hour), 0);
    checkOutput("rst_set_min", int'(setting_min), 0);
    checkOutput("rst_en_hour", int'(enable_hour), 0);
    checkOutput("rst_en_min", int'(enable_min), 0);
    reset_n = 1'b1;
    model_reset();

    // Setting sequence
    $display("[TB] setting");
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      pulses += int'(enable_hour);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      pulses += int'(enable_hour);
    end
    checkOutput("hour_pulses", pulses, 3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      pulses += int'(enable_min);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      pulses += int'(enable_min);
    end
    checkOutput("min_pulses", pulses, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    checkOutput("armed_after_set", int'(armed), 1);

    // Trigger and full ring
    $display("[TB] trigger");
    t_h = 7; t_m = 29; t_s = 59;
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("match_cycle_buzzer", int'(buzzer), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("trigger_buzzer", int'(buzzer), 1);
    ticks = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      ticks++;
    end while (buzzer && ticks < 100);
    checkOutput("ring_ticks", ticks, RING_SECS);
    checkOutput("armed_after_ring", int'(armed), 1);

    // Late arm during the matching second
    $display("[TB] late arm");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    t_h = 7; t_m = 30; t_s = 0;
    idle(2);
    arm_alarm();
    idle(5);
    checkOutput("late_arm_buzzer", int'(buzzer), 0);
    checkOutput("late_arm_armed", int'(armed), 1);

    // Snooze three times, fourth request ignored
    $display("[TB] snooze");
    ring_from_arm();
    checkOutput("snz_ring_start", int'(buzzer), 1);
    for (int s = 0; s < MAX_SNOOZE; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("snooze_entered", int'(snooze_active), 1);
      ticks = 0;
      do begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        ticks++;
      end while (!buzzer && ticks < 400);
      checkOutput("snooze_ticks", ticks, SNOOZE_MINS * 60);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("fourth_snooze_ignored", int'(snooze_active), 0);
    checkOutput("still_ringing", int'(buzzer), 1);

    // Mode beats stop
    $display("[TB] priority");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("prio_armed", int'(armed), 0);
    checkOutput("prio_buzzer", int'(buzzer), 0);

    // Async reset mid-ring
    $display("[TB] async reset");
    t_h = 12; t_m = 0; t_s = 0;
    idle(2);
    arm_alarm();
    ring_from_arm();
    checkOutput("pre_reset_buzzer", int'(buzzer), 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_buzzer", int'(buzzer), 0);
    checkOutput("async_armed", int'(armed), 0);
    model_reset();
    btn_mode = 1'b0; btn_inc = 1'b0; btn_stop = 1'b0; tick_1hz = 1'b0;
    t_h = 7; t_m = 30; t_s = 0;
    @(negedge clock);
    reset_n = 1'b1;
    idle(8);
    checkOutput("post_reset_buzzer", int'(buzzer), 0);

    // Randomized phase
    $display("[TB] random");
    a_h = $urandom_range(0, 23);
    a_m = $urandom_range(1, 59);
    for (int c = 0; c < 6000; c++) begin
      bit rm, ri, rs, rt;
      int j;
      j = $urandom_range(0, 299);
      if (j < 2) begin
        t_h = a_h; t_m = a_m - 1; t_s = 59;
      end else if (j == 2) begin
        t_h = a_h; t_m = a_m; t_s = 0;
      end
      rm = ($urandom_range(0, 79) == 0);
      ri = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 59) == 0);
      rt = ($urandom_range(0, 1) == 0);
      applyStimulus(rm, ri, rs, rt);
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
